// File: rtl/serial_frame_tx.sv
// ============================================================================
// Module   : serial_frame_tx
// Function : Framed parallel-to-serial transmitter (start, data, [parity], stop)
//            on an idle-high line. Optional even-parity bit: define PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_tx #(
    parameter int NUM_BITS     = 8,
    parameter bit SHIFT_MSB    = 1'b1,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_BITS - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NUM_BITS-1:0] r_shift;
    logic [NUM_BITS-1:0] w_shift_nxt;
    logic [NUM_BITS-1:0] w_shifted;
    logic                r_ser;
    logic                w_ser_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_out_bit;
    logic                w_bit_end;
`ifdef PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    // Shift direction decides which end of the word leaves first; vacated bits fill with 1.
    generate
        if (SHIFT_MSB) begin : g_msb_first
            assign w_out_bit = r_shift[NUM_BITS-1];
            assign w_shifted = {r_shift[NUM_BITS-2:0], 1'b1};
        end else begin : g_lsb_first
            assign w_out_bit = r_shift[0];
            assign w_shifted = {1'b1, r_shift[NUM_BITS-1:1]};
        end
    endgenerate

    assign w_bit_end = (r_cnt == c_CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_ser_nxt   = r_ser;
        w_done_nxt  = 1'b0;
`ifdef PARITY_EN
        w_parity_nxt = r_parity;
`endif

        if (r_state != IDLE) begin
            w_cnt_nxt = w_bit_end ? '0 : r_cnt + CNT_W'(1);
        end

        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = START;
                    w_shift_nxt = tx_data;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_ser_nxt   = 1'b0;
`ifdef PARITY_EN
                    w_parity_nxt = ^tx_data;
`endif
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_ser_nxt   = w_out_bit;
                    w_shift_nxt = w_shifted;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_idx == c_IDX_LAST) begin
`ifdef PARITY_EN
                        w_state_nxt = PARITY;
                        w_ser_nxt   = r_parity;
`else
                        w_state_nxt = STOP;
                        w_ser_nxt   = 1'b1;
`endif
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_ser_nxt   = w_out_bit;
                        w_shift_nxt = w_shifted;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_ser_nxt   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ser_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '1;
            r_ser   <= 1'b1;
            r_done  <= 1'b0;
`ifdef PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_ser   <= w_ser_nxt;
            r_done  <= w_done_nxt;
`ifdef PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign tx_ready   = (r_state == IDLE);
    assign tx_busy    = (r_state != IDLE);
    assign serial_out = r_ser;
    assign tx_done    = r_done;

    a_ready_busy: assert property (@(posedge clk) disable iff (!n_rst) tx_ready != tx_busy);
    a_done_pulse: assert property (@(posedge clk) disable iff (!n_rst) tx_done |=> !tx_done);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (MSB-first and LSB-first) with a
// scoreboard of accepted words checked against the observed serial frames.
`default_nettype none

module tb_serial_frame_tx;

    localparam int NB = 8;
    localparam int C  = 4;
`ifdef PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int F = (NB + 2 + P) * C;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          sel = 1'b1;
    logic          tx_valid = 1'b0;
    logic [NB-1:0] tx_data = '0;

    logic m_valid, m_ready, m_ser, m_busy, m_done;
    logic l_valid, l_ready, l_ser, l_busy, l_done;
    logic line, ready, busy, done;

    int errors = 0;
    int checks = 0;
    logic [NB-1:0] q_exp[$];

    assign m_valid = tx_valid & sel;
    assign l_valid = tx_valid & ~sel;
    assign line    = sel ? m_ser   : l_ser;
    assign ready   = sel ? m_ready : l_ready;
    assign busy    = sel ? m_busy  : l_busy;
    assign done    = sel ? m_done  : l_done;

    always #5 clk = ~clk;

    serial_frame_tx #(.NUM_BITS(NB), .SHIFT_MSB(1'b1), .CLKS_PER_BIT(C)) u_msb (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(m_valid),
        .tx_ready(m_ready), .serial_out(m_ser), .tx_busy(m_busy), .tx_done(m_done)
    );

    serial_frame_tx #(.NUM_BITS(NB), .SHIFT_MSB(1'b0), .CLKS_PER_BIT(C)) u_lsb (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(l_valid),
        .tx_ready(l_ready), .serial_out(l_ser), .tx_busy(l_busy), .tx_done(l_done)
    );

    // Expected line level k cycles after the transfer edge.
    function automatic logic exp_line(input logic [NB-1:0] w, input int k, input logic msb);
        int j;
        j = k / C;
        if (j == 0) return 1'b0;
        if (j <= NB) return msb ? w[NB-j] : w[j-1];
        if (P == 1 && j == NB + 1) return ^w;
        return 1'b1;
    endfunction

    task automatic start_tx(input logic [NB-1:0] w);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready: got %b want 1", ready);
        end
        tx_data  = w;
        tx_valid = 1'b1;
        q_exp.push_back(w);
        @(negedge clk);
    endtask

    // Called at the first negedge after the transfer edge; returns at sample k=F.
    task automatic monitor_frame(input bit hold, input int inject_k, output time t0,
                                 output logic par_bit);
        logic [NB-1:0] exp_w;
        logic [NB-1:0] rebuilt;
        int bad_line;
        int bad_ctl;
        int done_k;
        bad_line = 0;
        bad_ctl  = 0;
        done_k   = -1;
        rebuilt  = '0;
        par_bit  = 1'bx;
        t0       = $time;
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got size 0 want >0");
            exp_w = '0;
        end else begin
            exp_w = q_exp.pop_front();
        end
        if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = ~exp_w;
        end
        for (int k = 0; k <= F; k++) begin
            if (k > 0) @(negedge clk);
            if (inject_k >= 0 && k == inject_k) begin
                tx_valid = 1'b1;
                tx_data  = '1;
            end
            if (inject_k >= 0 && k == inject_k + 1) tx_valid = 1'b0;
            if (line !== exp_line(exp_w, k, sel)) bad_line++;
            if (k >= C && k < (NB + 1) * C && (k % C) == C / 2)
                rebuilt = sel ? {rebuilt[NB-2:0], line} : {line, rebuilt[NB-1:1]};
            if (k == (NB + 1) * C + 1) par_bit = line;
            if (done === 1'b1) begin
                if (done_k != -1) bad_ctl++;
                done_k = k;
            end
            if (k < F && (ready !== 1'b0 || busy !== 1'b1)) bad_ctl++;
        end
        checks++;
        if (bad_line != 0) begin
            errors++;
            $display("FAIL line_bits word=%h: got %0d wrong samples want 0", exp_w, bad_line);
        end
        checks++;
        if (rebuilt !== exp_w) begin
            errors++;
            $display("FAIL rx_word: got %h want %h", rebuilt, exp_w);
        end
        checks++;
        if (done_k != F) begin
            errors++;
            $display("FAIL done_time: got k=%0d want k=%0d", done_k, F);
        end
        checks++;
        if (bad_ctl != 0) begin
            errors++;
            $display("FAIL ready_busy_in_frame: got %0d bad cycles want 0", bad_ctl);
        end
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || line !== 1'b1) begin
            errors++;
            $display("FAIL end_of_frame: got rdy=%b busy=%b line=%b want 1 0 1", ready, busy, line);
        end
    endtask

    task automatic test_reset();
        #12;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({m_ser, m_ready, m_busy, m_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_msb: got %b want 1100", {m_ser, m_ready, m_busy, m_done});
        end
        checks++;
        if ({l_ser, l_ready, l_busy, l_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_lsb: got %b want 1100", {l_ser, l_ready, l_busy, l_done});
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_msb_first();
        time  t;
        logic pb;
        sel = 1'b1;
        start_tx(8'hA5);
        monitor_frame(1'b0, -1, t, pb);
    endtask

    task automatic test_lsb_first();
        time  t;
        logic pb;
        sel = 1'b0;
        start_tx(8'hA5);
        monitor_frame(1'b0, -1, t, pb);
        start_tx(8'h01);
        monitor_frame(1'b0, -1, t, pb);
        sel = 1'b1;
    endtask

    task automatic test_back_to_back();
        time  t0;
        time  t1;
        logic pb;
        sel = 1'b1;
        @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        q_exp.push_back(8'h3C);
        q_exp.push_back(8'hC3);
        @(negedge clk);
        tx_data = 8'hC3;
        monitor_frame(1'b1, -1, t0, pb);
        @(negedge clk);
        monitor_frame(1'b0, -1, t1, pb);
        checks++;
        if (t1 - t0 != (F + 1) * 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0t want %0d", t1 - t0, (F + 1) * 10);
        end
    endtask

    task automatic test_busy_reject();
        time  t;
        logic pb;
        sel = 1'b1;
        start_tx(8'h5A);
        monitor_frame(1'b0, 10, t, pb);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || line !== 1'b1) begin
            errors++;
            $display("FAIL no_extra_transfer: got rdy=%b busy=%b line=%b want 1 0 1", ready, busy, line);
        end
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d want 0", q_exp.size());
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        time  t;
        logic pb;
        sel = 1'b1;
        start_tx(8'h07);
        monitor_frame(1'b0, -1, t, pb);
        checks++;
        if (pb !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: got %b want 1", pb);
        end
        start_tx(8'h03);
        monitor_frame(1'b0, -1, t, pb);
        checks++;
        if (pb !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: got %b want 0", pb);
        end
    endtask
`endif

    task automatic test_abort();
        int   bad;
        logic [NB-1:0] drop;
        sel = 1'b1;
        bad = 0;
        start_tx(8'hA5);
        tx_valid = 1'b0;
        drop = q_exp.pop_front();
        repeat (20) @(negedge clk);
        checks++;
        if (line !== exp_line(drop, 20, 1'b1)) begin
            errors++;
            $display("FAIL abort_pre: got %b want %b", line, exp_line(drop, 20, 1'b1));
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({line, ready, busy, done} !== 4'b1100) begin
            errors++;
            $display("FAIL abort_reset: got %b want 1100", {line, ready, busy, done});
        end
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || line !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d bad cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_busy_reject();
`ifdef PARITY_EN
        test_parity();
`endif
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_frame_tx.md
# serial_frame_tx

Parallel-to-serial framed transmitter for the MCU serial link. Accepts a parallel word through a valid/ready handshake, then drives it onto a single idle-high serial line as start bit, NUM_BITS data bits, optional parity bit and stop bit. Each bit is held for a programmable number of clock cycles. This is the transmit end for the block's serial-to-parallel receive shift register: line idles at 1, and bit order is selectable so the receiver reconstructs the word unchanged.

## Interface
- NUM_BITS, 8, data bits per frame (>= 2)
- SHIFT_MSB, 1, 1 = MSB transmitted first, 0 = LSB transmitted first
- CLKS_PER_BIT, 10, clock cycles each serial bit is held (>= 2)

- clk  input  1  clock, rising edge
- n_rst  input  1  reset, asynchronous, active-low
- tx_data  input  NUM_BITS  word to transmit, sampled only on handshake
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word (high only in IDLE)
- serial_out  output  1  serial line, registered, idle high
- tx_busy  output  1  frame in progress (any state except IDLE)
- tx_done  output  1  one-cycle pulse when a frame completes

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when PARITY_EN is defined), STOP.
- Handshake: a transfer occurs on a rising edge where tx_valid && tx_ready. No queue. tx_valid while busy is ignored, not stored.
- On transfer:
  - tx_data is loaded into the internal shift register.
  - Bit-period counter is cleared; bit index is cleared.
  - Next state is START; serial_out is driven to 0.
- START: serial_out = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: one data bit per bit period. Bit index counts 0..NUM_BITS-1.
  - SHIFT_MSB=1: register shifts left and serial_out takes the current MSB.
  - SHIFT_MSB=0: register shifts right and serial_out takes the current LSB.
  - After the last bit period, go to PARITY if enabled, otherwise STOP.
- PARITY: serial_out = even parity (XOR of the latched data bits) for CLKS_PER_BIT cycles, then STOP.
- STOP: serial_out = 1 for CLKS_PER_BIT cycles. Then go to IDLE with a tx_done pulse.
- Changes on tx_data after the transfer edge have no effect on the frame in progress.
- Bit-period counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.

## Timing
- Reset values (asynchronous, take effect immediately):
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register all ones; counters 0; state IDLE.
- Let transfer edge be T:
  - serial_out falls at T.
  - Data bit i occupies cycles [T+(1+i)*CLKS_PER_BIT, T+(2+i)*CLKS_PER_BIT).
  - Frame length F = (NUM_BITS+2)*CLKS_PER_BIT, plus CLKS_PER_BIT if PARITY_EN.
- At edge T+F: state=IDLE, tx_done=1 for exactly one cycle, tx_ready=1, tx_busy=0.
- Back-to-back: if tx_valid is held high, the next transfer is at T+F+1. The line is high for CLKS_PER_BIT+1 cycles between frames.
- tx_ready and tx_busy are complementary in every cycle after reset.
- Reset mid-frame aborts the frame. The line returns high immediately, and no tx_done is produced.

## Configuration
- PARITY_EN defined: PARITY state is compiled in and frames carry an even-parity bit between data and stop. F grows by CLKS_PER_BIT.
- PARITY_EN undefined: PARITY state and parity logic are absent; STOP follows the last data bit directly.

## Test plan
- Reset: assert n_rst=0 mid-cycle -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0 with no clock edge needed.
- NUM_BITS=8, CLKS_PER_BIT=4, SHIFT_MSB=1, send 0xA5:
  - line reads 0, 1,0,1,0,0,1,0,1, then 1, each held 4 cycles;
  - tx_done at T+40;
  - looped into the receiver, parallel_out = 0xA5.
- Same with SHIFT_MSB=0, send 0xA5 -> data bits 1,0,1,0,0,1,0,1 in LSB-first order (0xA5 is a bit palindrome). Repeat with 0x01 -> first data bit 1, remaining seven 0.
- Back-to-back: tx_valid held high with 0x3C then 0xC3 -> second start bit falls at T+41, line high 5 cycles between frames, two tx_done pulses.
- Busy rejection: assert tx_valid with 0xFF at T+10 -> ignored; frame still carries the original word; no extra transfer.
- PARITY_EN defined, send 0x07 -> parity bit 1, F=44. Send 0x03 -> parity bit 0. Reset at T+20 -> line high immediately, no tx_done.
